bpmc_pulse_sequencer: RTL
=========================

# bpmc_pulse_sequencer

Timing controller for the bipolar pulse-shaping path of the arbitrary function generator. It generates the front-edge strobe (`Front_out`) that drives the pulse-front input (`DIN_1`) and the rear-edge strobe (`Rear_out`) that drives the pulse-rear input (`DIN_2`). Pulse width, period and burst length are programmable. The block issues bursts or continuous pulse trains on command, with a graceful stop that never leaves a pulse without its rear edge.

## Interface
Parameters:
- `CNT_W`, 16, width of the `Width`/`Period` fields and the internal cycle counter
- `BURST_W`, 8, width of the burst-count field

Ports:
- `Clock`  in  1  single system clock; all logic is on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Start`  in  1  single-cycle request to begin a sequence; sampled only in IDLE
- `Stop`  in  1  request to end the sequence gracefully; level, sampled every cycle
- `Width`  in  CNT_W  high time in cycles, from the Front strobe to the Rear strobe
- `Period`  in  CNT_W  cycles between successive Front strobes
- `Burst`  in  BURST_W  number of pulses; 0 means continuous until Stop
- `Front_out`  out  1  single-cycle strobe to `DIN_1`
- `Rear_out`  out  1  single-cycle strobe to `DIN_2`
- `Busy`  out  1  high while a sequence is active
- `Done`  out  1  single-cycle strobe when the sequence ends (normal end or Stop)
- `Cfg_Err`  out  1  single-cycle strobe when a Start is rejected for bad configuration

## Operation
- States:
  - IDLE
  - ARM (exists only with the macro; see Configuration)
  - HIGH: counting toward the Rear strobe
  - LOW: counting toward the next Front strobe
- Accepting a Start (IDLE, `Start`=1, `Stop`=0):
  - `Width`, `Period` and `Burst` are latched; later input changes are ignored until IDLE.
  - The configuration is valid only if Width ≥ 1 and Period > Width.
  - If invalid: `Cfg_Err`=1 for one cycle and the block stays in IDLE.
- Counter behaviour:
  - `cnt` is 0 on each Front cycle.
  - `Rear_out` fires when cnt == Width; the state then moves HIGH→LOW.
  - At cnt == Period−1 the next cycle is a new Front with cnt = 0.
- Burst accounting: the remaining count decrements on each Front. When the pulse that consumed the last count reaches cnt == Period−1, the next cycle is IDLE with `Done`=1.
- Continuous mode (Burst=0): pulses repeat until `Stop`.
- Stop handling:
  - Stop in LOW: next cycle IDLE, `Done`=1; no further Front.
  - Stop in HIGH: a stop-pending flag is set and the Rear strobe is still issued at cnt == Width; the next cycle is IDLE with `Done`=1.
- Start while Busy is ignored. Start and Stop together in IDLE: Stop wins and Start is ignored.
- Reset values: all outputs 0, state IDLE, counters 0.
  - Reset mid-pulse drops the pending Rear strobe. The downstream pulse stages must be reset by the same `Reset`.

## Timing
- Start accepted at cycle t:
  - `Front_out`=1 at t+1, and `Busy` rises at t+1.
  - `Rear_out`=1 at t+1+Width.
  - The k-th Front (k ≥ 0) is at t+1+k·Period.
- Normal burst end: `Done`=1 and `Busy`=0 at t+1+Burst·Period.
- `Cfg_Err` fires at t+1.
- All outputs are registered. `Front_out` and `Rear_out` are never high in the same cycle (guaranteed by Period > Width ≥ 1).

## Configuration
- Macro: `BPMC_SEQ_TRIG_EN`.
- Defined:
  - Adds port `Trig` (in, 1).
  - An accepted Start enters ARM, with `Busy`=1.
  - The first Front is issued the cycle after `Trig` is sampled high in ARM.
  - Stop in ARM leads to IDLE with `Done` the next cycle.
  - All other timing is measured from the Trig-sampled cycle instead of t.
- Undefined: no `Trig` port, no ARM state; the behaviour is exactly as in Operation and Timing.

## Structure
- Shared package `bpmc_pkg`:
  - state enum (IDLE, ARM, HIGH, LOW)
  - default `CNT_W` and `BURST_W` constants
- One sub-module, `bpmc_seq_counter`: the cycle counter with clear, and equality compare outputs against Width and Period−1.
- The FSM, burst counter and stop-pending flag live in the top level.

## Test plan
- Width=3, Period=8, Burst=2, Start at t=10 → Front at 11 and 19; Rear at 14 and 22; Done at 27; Busy high 11–26.
- Width=0 or Period=Width=5 → Cfg_Err at t+1; Busy, Front and Done stay 0.
- Burst=0, Width=2, Period=4, Stop high for one cycle during HIGH → Rear still issued at cnt==2; Done the next cycle; no further Front.
- Start pulsed while Busy, and Start+Stop together in IDLE → both ignored; the train is unchanged or no sequence starts.
- Reset asserted at cnt==1 of a Width=4 pulse → all outputs 0 next cycle; no Rear; a new Start afterwards works normally.
- With `BPMC_SEQ_TRIG_EN`: Start at 10, Trig high at 20 → Front at 21; Stop in ARM → Done the next cycle with no Front.

Source files
------------

// File: rtl/bpmc_pkg.sv
// Shared definitions for the bipolar pulse-shaping sequencer.
//   - seq_state_e   : sequencer FSM state encoding
//   - CNT_W_DEF     : default width of Width/Period and the cycle counter
//   - BURST_W_DEF   : default width of the burst-count field
//   - cfg_ok()      : configuration check applied to an accepted Start
package bpmc_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned BURST_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } seq_state_e;

    // A pulse needs at least one high cycle and at least one low cycle.
    function automatic logic cfg_ok(input logic [31:0] width, input logic [31:0] period);
        return (width != 32'd0) && (period > width);
    endfunction

endpackage

// File: rtl/bpmc_pulse_sequencer_if.sv
// Control/strobe bundle of the pulse sequencer.
//   master : the controller side (drives Start/Stop/config, sees strobes)
//   slave  : the sequencer side
// Signals:
//   Start, Stop, Width[CNT_W], Period[CNT_W], Burst[BURST_W]  (master -> slave)
//   Front_out, Rear_out, Busy, Done, Cfg_Err                  (slave -> master)
//   Trig  (master -> slave, only when BPMC_SEQ_TRIG_EN is defined)
interface bpmc_pulse_sequencer_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               Start;
    logic               Stop;
    logic [CNT_W-1:0]   Width;
    logic [CNT_W-1:0]   Period;
    logic [BURST_W-1:0] Burst;
`ifdef BPMC_SEQ_TRIG_EN
    logic               Trig;
`endif
    logic               Front_out;
    logic               Rear_out;
    logic               Busy;
    logic               Done;
    logic               Cfg_Err;

    modport master (
        output Start, Stop, Width, Period, Burst,
`ifdef BPMC_SEQ_TRIG_EN
        output Trig,
`endif
        input  Front_out, Rear_out, Busy, Done, Cfg_Err
    );

    modport slave (
        input  Start, Stop, Width, Period, Burst,
`ifdef BPMC_SEQ_TRIG_EN
        input  Trig,
`endif
        output Front_out, Rear_out, Busy, Done, Cfg_Err
    );

endinterface

// File: rtl/bpmc_seq_counter.sv
// Cycle counter of the pulse sequencer.
// Ports:
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   clr          : force the count to 0 on the next edge (otherwise +1)
//   width        : latched pulse width
//   period       : latched pulse period
//   rear_next    : the next cycle is the cnt == width cycle (Rear strobe)
//   last_cyc     : current cycle is cnt == period-1
// Because the strobes are registered in the FSM, the Rear compare looks
// one cycle ahead (cnt == width-1) so that Rear_out is high when cnt == width.
module bpmc_seq_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] period,
    output logic             rear_next,
    output logic             last_cyc
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    // Free-running cycle count, cleared by the FSM on Front cycles and when idle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign rear_next = (cnt_r == (width - CNT_ONE));
    assign last_cyc  = (cnt_r == (period - CNT_ONE));

endmodule

// File: rtl/bpmc_pulse_sequencer.sv
// Pulse sequencer for the bipolar pulse-shaping path: issues the Front
// strobe (to DIN_1) and the Rear strobe (to DIN_2) for bursts or continuous
// trains, with a graceful stop that never drops a pending Rear edge.
// Ports:
//   Clock : system clock, rising edge
//   Reset : synchronous active-high reset (downstream pulse stages must
//           share it, since a reset mid-pulse drops the Rear strobe)
//   bus   : bpmc_pulse_sequencer_if.slave (Start/Stop/Width/Period/Burst in,
//           Front_out/Rear_out/Busy/Done/Cfg_Err out; Trig with the macro)
// Build option: BPMC_SEQ_TRIG_EN adds the Trig input and the ARM state; an
// accepted Start then waits in ARM until Trig is sampled high.
module bpmc_pulse_sequencer
    import bpmc_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic                    Clock,
    input  logic                    Reset,
    bpmc_pulse_sequencer_if.slave   bus
);

    localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

    seq_state_e         state_r;
    logic [CNT_W-1:0]   width_r;
    logic [CNT_W-1:0]   period_r;
    logic [BURST_W-1:0] rem_r;        // pulses still to issue after the current one
    logic               cont_r;       // continuous mode (Burst == 0)
    logic               stop_pend_r;  // Stop seen in HIGH, finish after Rear
    logic               front_r;
    logic               rear_r;
    logic               busy_r;
    logic               done_r;
    logic               cfg_err_r;

    logic               clr_s;
    logic               rear_next_s;
    logic               last_cyc_s;
    logic               cfg_ok_s;

    assign cfg_ok_s = cfg_ok(32'(bus.Width), 32'(bus.Period));

    bpmc_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .Clock     (Clock),
        .Reset     (Reset),
        .clr       (clr_s),
        .width     (width_r),
        .period    (period_r),
        .rear_next (rear_next_s),
        .last_cyc  (last_cyc_s)
    );

    // Counter clear: counting only runs inside a pulse; leaving LOW (new Front or end) restarts it.
    always_comb begin
        clr_s = 1'b1;
        case (state_r)
            ST_HIGH: clr_s = 1'b0;
            ST_LOW:  clr_s = bus.Stop | stop_pend_r | last_cyc_s;
            default: clr_s = 1'b1;
        endcase
    end

    // Sequencer FSM with burst accounting, stop-pending flag and registered strobes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            width_r     <= CNT_ZERO;
            period_r    <= CNT_ZERO;
            rem_r       <= BURST_ZERO;
            cont_r      <= 1'b0;
            stop_pend_r <= 1'b0;
            front_r     <= 1'b0;
            rear_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            front_r   <= 1'b0;
            rear_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    stop_pend_r <= 1'b0;
                    // Stop has priority over a simultaneous Start.
                    if (bus.Start && !bus.Stop) begin
                        width_r  <= bus.Width;
                        period_r <= bus.Period;
                        rem_r    <= bus.Burst - BURST_ONE;
                        cont_r   <= (bus.Burst == BURST_ZERO);
                        if (cfg_ok_s) begin
                            busy_r <= 1'b1;
`ifdef BPMC_SEQ_TRIG_EN
                            state_r <= ST_ARM;
`else
                            state_r <= ST_HIGH;
                            front_r <= 1'b1;
`endif
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
`ifdef BPMC_SEQ_TRIG_EN
                    if (bus.Stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (bus.Trig) begin
                        state_r <= ST_HIGH;
                        front_r <= 1'b1;
                    end
`else
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
`endif
                end
                ST_HIGH: begin
                    if (bus.Stop) begin
                        stop_pend_r <= 1'b1;
                    end
                    if (rear_next_s) begin
                        state_r <= ST_LOW;
                        rear_r  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (bus.Stop || stop_pend_r) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        stop_pend_r <= 1'b0;
                    end else if (last_cyc_s) begin
                        if (!cont_r && (rem_r == BURST_ZERO)) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_HIGH;
                            front_r <= 1'b1;
                            if (!cont_r) begin
                                rem_r <= rem_r - BURST_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Front_out = front_r;
    assign bus.Rear_out  = rear_r;
    assign bus.Busy      = busy_r;
    assign bus.Done      = done_r;
    assign bus.Cfg_Err   = cfg_err_r;

endmodule
